// File: rtl/covariance_predict_engine.sv
// Kalman covariance time update P <= A*P*A' + Q on one shared MAC, rounding and saturating per element.
// Latency 2*NOS^3 + S + 1 enabled cycles from start; no backpressure, clk_en stalls every register.
module covariance_predict_engine #(
  parameter int WIDTH      = 16,
  parameter int NOS        = 4,
  parameter int FRAC_BITS  = 8,
  parameter int SYMMETRIZE = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clk_en,
  input  logic                       load_p0,
  input  logic                       start,
  input  logic [NOS*NOS*WIDTH-1:0]   A,
  input  logic [NOS*NOS*WIDTH-1:0]   Q,
  input  logic [NOS*NOS*WIDTH-1:0]   P0,
  output logic [NOS*NOS*WIDTH-1:0]   P,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf
);

  localparam int IW = $clog2(NOS);
  localparam int AW = 2*WIDTH + $clog2(NOS) + 1;
  localparam logic [IW-1:0] ONE      = IW'(1);
  localparam logic [IW-1:0] LAST     = IW'(NOS-1);
  localparam logic [IW-1:0] LAST_ROW = IW'(NOS-2);
  localparam logic signed [AW-1:0]    HALF  = AW'(1) << (FRAC_BITS-1);
  localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL1 = 3'd1;
  localparam logic [2:0] S_MUL2 = 3'd2;
  localparam logic [2:0] S_SYM  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]              state;
  logic [IW-1:0]           i_idx, j_idx, k_idx;
  logic signed [AW-1:0]    acc;
  logic signed [WIDTH-1:0] p_m  [NOS][NOS];
  logic signed [WIDTH-1:0] t_m  [NOS][NOS];
  logic signed [WIDTH-1:0] a_m  [NOS][NOS];
  logic signed [WIDTH-1:0] q_m  [NOS][NOS];
  logic signed [WIDTH-1:0] p0_m [NOS][NOS];

  for (genvar r = 0; r < NOS; r++) begin : g_row
    for (genvar c = 0; c < NOS; c++) begin : g_col
      assign a_m[r][c]  = A[(r*NOS+c)*WIDTH +: WIDTH];
      assign q_m[r][c]  = Q[(r*NOS+c)*WIDTH +: WIDTH];
      assign p0_m[r][c] = P0[(r*NOS+c)*WIDTH +: WIDTH];
      assign P[(r*NOS+c)*WIDTH +: WIDTH] = p_m[r][c];
    end
  end

  logic signed [WIDTH-1:0]   mul_a, mul_b, fin_val, sym_val;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      acc_base, acc_sum, rnd, shr;
  logic signed [WIDTH:0]     pair_sum;
  logic                      fin_sat, last_k, last_j, last_i;

  always_comb begin
    last_k = (k_idx == LAST);
    last_j = (j_idx == LAST);
    last_i = (i_idx == LAST);
    // MUL1 forms A*P, MUL2 forms T*A'; the same multiplier serves both.
    mul_a  = (state == S_MUL1) ? a_m[i_idx][k_idx] : t_m[i_idx][k_idx];
    mul_b  = (state == S_MUL1) ? p_m[k_idx][j_idx] : a_m[j_idx][k_idx];
    prod   = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
    if (k_idx != '0)
      acc_base = acc;
    else if (state == S_MUL2)
      acc_base = {{(AW-WIDTH){q_m[i_idx][j_idx][WIDTH-1]}}, q_m[i_idx][j_idx]} <<< FRAC_BITS;
    else
      acc_base = '0;
    acc_sum = acc_base + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    rnd     = acc_sum + HALF;
    shr     = rnd >>> FRAC_BITS;
    fin_sat = (shr[AW-1:WIDTH-1] != {(AW-WIDTH+1){shr[AW-1]}});
    fin_val = fin_sat ? (shr[AW-1] ? W_MIN : W_MAX) : shr[WIDTH-1:0];
    pair_sum = {p_m[i_idx][j_idx][WIDTH-1], p_m[i_idx][j_idx]}
             + {p_m[j_idx][i_idx][WIDTH-1], p_m[j_idx][i_idx]};
    sym_val  = pair_sum[WIDTH:1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      i_idx <= '0;
      j_idx <= '0;
      k_idx <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      for (int r = 0; r < NOS; r++) begin
        for (int c = 0; c < NOS; c++) begin
          p_m[r][c] <= '0;
          t_m[r][c] <= '0;
        end
      end
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (load_p0) begin
            for (int r = 0; r < NOS; r++)
              for (int c = 0; c < NOS; c++)
                p_m[r][c] <= p0_m[r][c];
          end else if (start) begin
            ovf   <= 1'b0;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            state <= S_MUL1;
          end
        end
        S_MUL1, S_MUL2: begin
          acc <= acc_sum;
          if (last_k) begin
            if (fin_sat) ovf <= 1'b1;
            // P is no longer read during MUL2, so it can be overwritten in place.
            if (state == S_MUL1) t_m[i_idx][j_idx] <= fin_val;
            else                 p_m[i_idx][j_idx] <= fin_val;
            k_idx <= '0;
            if (last_j) begin
              j_idx <= '0;
              if (last_i) begin
                i_idx <= '0;
                if (state == S_MUL1) begin
                  state <= S_MUL2;
                end else if (SYMMETRIZE != 0) begin
                  j_idx <= ONE;
                  state <= S_SYM;
                end else begin
                  state <= S_DONE;
                end
              end else begin
                i_idx <= i_idx + ONE;
              end
            end else begin
              j_idx <= j_idx + ONE;
            end
          end else begin
            k_idx <= k_idx + ONE;
          end
        end
        S_SYM: begin
          p_m[i_idx][j_idx] <= sym_val;
          p_m[j_idx][i_idx] <= sym_val;
          if (last_j) begin
            if (i_idx == LAST_ROW) begin
              state <= S_DONE;
            end else begin
              i_idx <= i_idx + ONE;
              j_idx <= i_idx + ONE + ONE;
            end
          end else begin
            j_idx <= j_idx + ONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_covariance_predict_engine.sv
// Bench for covariance_predict_engine: directed and random predictions on NOS=2 (with and without
// symmetrisation) and NOS=3 instances, compared against a plain-arithmetic matrix model.
module tb_covariance_predict_engine;

  logic clk, reset_n, clk_en, load_p0, start;
  logic [63:0]  a2, q2, p02, p_s, p_n;
  logic [143:0] a3, q3, p03, p_3;
  logic busy_s, done_s, ovf_s, busy_n, done_n, ovf_n, busy_3, done_3, ovf_3;

  covariance_predict_engine #(.WIDTH(16), .NOS(2), .FRAC_BITS(8), .SYMMETRIZE(1)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .load_p0(load_p0), .start(start),
    .A(a2), .Q(q2), .P0(p02), .P(p_s), .busy(busy_s), .done(done_s), .ovf(ovf_s));

  covariance_predict_engine #(.WIDTH(16), .NOS(2), .FRAC_BITS(8), .SYMMETRIZE(0)) dut_ns (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .load_p0(load_p0), .start(start),
    .A(a2), .Q(q2), .P0(p02), .P(p_n), .busy(busy_n), .done(done_n), .ovf(ovf_n));

  covariance_predict_engine #(.WIDTH(16), .NOS(3), .FRAC_BITS(8), .SYMMETRIZE(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .load_p0(load_p0), .start(start),
    .A(a3), .Q(q3), .P0(p03), .P(p_3), .busy(busy_3), .done(done_3), .ovf(ovf_3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int errors  = 0;
  longint ma[3][3], mq[3][3], mp0[3][3], mexp[3][3], gp[3][3];
  bit movf;

  // ---------------- reference model ----------------
  function automatic longint fin(longint x);
    longint r;
    r = (x + 128) >>> 8;
    if (r > 32767)  begin r = 32767;  movf = 1'b1; end
    if (r < -32768) begin r = -32768; movf = 1'b1; end
    return r;
  endfunction

  task automatic model(input int n, input bit sym);
    longint t[3][3];
    longint s;
    movf = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += ma[i][k] * mp0[k][j];
        t[i][j] = fin(s);
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = mq[i][j] * 256;
        for (int k = 0; k < n; k++) s += t[i][k] * ma[j][k];
        mexp[i][j] = fin(s);
      end
    if (sym)
      for (int i = 0; i < n; i++)
        for (int j = i + 1; j < n; j++) begin
          s = (mexp[i][j] + mexp[j][i]) >>> 1;
          mexp[i][j] = s;
          mexp[j][i] = s;
        end
  endtask

  // ---------------- drive / observe ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mats();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 0; mq[r][c] = 0; mp0[r][c] = 0;
      end
  endtask

  task automatic pack_inputs();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a3[(r*3+c)*16 +: 16]  = 16'(ma[r][c]);
        q3[(r*3+c)*16 +: 16]  = 16'(mq[r][c]);
        p03[(r*3+c)*16 +: 16] = 16'(mp0[r][c]);
        if (r < 2 && c < 2) begin
          a2[(r*2+c)*16 +: 16]  = 16'(ma[r][c]);
          q2[(r*2+c)*16 +: 16]  = 16'(mq[r][c]);
          p02[(r*2+c)*16 +: 16] = 16'(mp0[r][c]);
        end
      end
  endtask

  task automatic grab(input int which);
    logic signed [15:0] v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        v = 16'sd0;
        if (which == 0 && r < 2 && c < 2) v = p_s[(r*2+c)*16 +: 16];
        if (which == 1 && r < 2 && c < 2) v = p_n[(r*2+c)*16 +: 16];
        if (which == 2) v = p_3[(r*3+c)*16 +: 16];
        gp[r][c] = longint'(v);
      end
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return done_s;
      1:       return done_n;
      default: return done_3;
    endcase
  endfunction

  task automatic do_load();
    load_p0 = 1'b1;
    tick();
    load_p0 = 1'b0;
  endtask

  // Edge count includes the edge that samples start.
  task automatic launch(input int which, input int budget, output int edges);
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (get_done(which) == 1'b0 && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic settle();
    int n = 0;
    while ((busy_s || busy_n || busy_3) && n < 300) begin
      tick();
      n++;
    end
    tick();
  endtask

  function automatic longint rnd(input int r);
    return longint'($urandom_range(2*r)) - longint'(r);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b1; clk_en = 1'b1; load_p0 = 1'b0; start = 1'b0;
    clear_mats();
    pack_inputs();
    #2 reset_n = 1'b0;
    tick();
    vectors++;
    if ({busy_s, done_s, ovf_s, busy_n, busy_3, done_3, ovf_3} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0", {busy_s, done_s, ovf_s, busy_n, busy_3, done_3, ovf_3});
    end
    vectors++;
    if (p_s !== '0 || p_n !== '0 || p_3 !== '0) begin
      errors++;
      $display("FAIL reset_p got %h/%h/%h want 0", p_s, p_n, p_3);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int e;
    clear_mats();
    for (int d = 0; d < 2; d++) begin ma[d][d] = 256; mp0[d][d] = 256; mq[d][d] = 1; end
    pack_inputs();
    do_load();
    grab(0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mp0[r][c]) begin
          errors++;
          $display("FAIL load_p0 P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mp0[r][c]);
        end
      end
    launch(0, 60, e);
    vectors++;
    if (e !== 18) begin errors++; $display("FAIL identity_latency got %0d want 18", e); end
    vectors++;
    if (ovf_s !== 1'b0) begin errors++; $display("FAIL identity_ovf got %b want 0", ovf_s); end
    model(2, 1'b1);
    grab(0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mexp[r][c] || (r == c && gp[r][c] !== 257)) begin
          errors++;
          $display("FAIL identity P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mexp[r][c]);
        end
      end
    tick();
    vectors++;
    if (busy_s !== 1'b0 || done_s !== 1'b0) begin
      errors++;
      $display("FAIL identity_after_done busy/done got %b%b want 00", busy_s, done_s);
    end
    settle();
  endtask

  task automatic test_shear();
    int e;
    clear_mats();
    ma[0][0] = 256; ma[0][1] = 256; ma[1][1] = 256;
    mp0[0][0] = 256; mp0[1][1] = 256;
    pack_inputs();
    do_load();
    launch(0, 60, e);
    vectors++;
    if (e !== 18) begin errors++; $display("FAIL shear_latency got %0d want 18", e); end
    model(2, 1'b1);
    grab(0);
    vectors++;
    if (gp[0][0] !== 512 || gp[0][1] !== 256) begin
      errors++;
      $display("FAIL shear_literal got %0d,%0d want 512,256", gp[0][0], gp[0][1]);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mexp[r][c]) begin
          errors++;
          $display("FAIL shear P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mexp[r][c]);
        end
      end
    settle();
  endtask

  task automatic test_saturate();
    int e;
    clear_mats();
    for (int d = 0; d < 2; d++) begin ma[d][d] = 32767; mp0[d][d] = 32767; end
    pack_inputs();
    do_load();
    launch(0, 60, e);
    model(2, 1'b1);
    grab(0);
    vectors++;
    if (ovf_s !== movf || movf !== 1'b1) begin
      errors++; $display("FAIL sat_ovf got %b want %b", ovf_s, movf);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mexp[r][c]) begin
          errors++;
          $display("FAIL sat P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mexp[r][c]);
        end
      end
    settle();
    vectors++;
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", ovf_s); end
    clear_mats();
    for (int d = 0; d < 2; d++) begin ma[d][d] = 256; mp0[d][d] = 256; end
    pack_inputs();
    do_load();
    launch(0, 60, e);
    model(2, 1'b1);
    grab(0);
    vectors++;
    if (ovf_s !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", ovf_s); end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mexp[r][c]) begin
          errors++;
          $display("FAIL sat_recover P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mexp[r][c]);
        end
      end
    settle();
  endtask

  task automatic test_symmetrize();
    int e;
    longint want[3];
    want[0] = 1; want[1] = -2; want[2] = 3;
    for (int pass = 0; pass < 3; pass++) begin
      clear_mats();
      for (int d = 0; d < 2; d++) ma[d][d] = 256;
      mq[0][1] = (pass == 1) ? -3 : 3;
      pack_inputs();
      do_load();
      launch((pass == 2) ? 1 : 0, 60, e);
      vectors++;
      if (e !== ((pass == 2) ? 17 : 18)) begin
        errors++; $display("FAIL sym_latency pass %0d got %0d", pass, e);
      end
      model(2, pass != 2);
      grab((pass == 2) ? 1 : 0);
      vectors++;
      if (gp[0][1] !== want[pass]) begin
        errors++; $display("FAIL sym_literal pass %0d got %0d want %0d", pass, gp[0][1], want[pass]);
      end
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          vectors++;
          if (gp[r][c] !== mexp[r][c]) begin
            errors++;
            $display("FAIL sym pass %0d P[%0d][%0d] got %0d want %0d", pass, r, c, gp[r][c], mexp[r][c]);
          end
        end
      vectors++;
      if (ovf_n !== 1'b0 && pass == 2) begin errors++; $display("FAIL sym_ovf got %b want 0", ovf_n); end
      settle();
    end
  endtask

  task automatic test_clk_en();
    int en_edges, clocks;
    logic en;
    clear_mats();
    for (int d = 0; d < 2; d++) begin ma[d][d] = 256; mp0[d][d] = 256; mq[d][d] = 1; end
    pack_inputs();
    do_load();
    clk_en = 1'b1;
    start = 1'b1;
    tick();
    en_edges = 1;
    clocks = 1;
    while (done_s == 1'b0 && clocks < 200) begin
      start  = (clocks == 6);
      clk_en = ~clk_en;
      en     = clk_en;
      tick();
      clocks++;
      if (en) en_edges++;
    end
    start = 1'b0;
    vectors++;
    if (en_edges !== 18) begin errors++; $display("FAIL clken_latency got %0d want 18", en_edges); end
    clk_en = 1'b0;
    tick();
    vectors++;
    if (done_s !== 1'b1) begin errors++; $display("FAIL clken_done_hold got %b want 1", done_s); end
    clk_en = 1'b1;
    tick();
    vectors++;
    if (done_s !== 1'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL clken_done_drop got %b%b want 00", done_s, busy_s);
    end
    model(2, 1'b1);
    grab(0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mexp[r][c]) begin
          errors++;
          $display("FAIL clken P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mexp[r][c]);
        end
      end
    settle();
  endtask

  task automatic test_reset_mid();
    int e;
    clear_mats();
    ma[0][0] = 256; ma[0][1] = 256; ma[1][1] = 256;
    mp0[0][0] = 256; mp0[1][1] = 256;
    pack_inputs();
    do_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    vectors++;
    if (busy_s !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", busy_s); end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || p_s !== '0) begin
      errors++; $display("FAIL rstmid_abort busy %b P %h want 0", busy_s, p_s);
    end
    tick();
    reset_n = 1'b1;
    tick();
    do_load();
    launch(0, 60, e);
    vectors++;
    if (e !== 18) begin errors++; $display("FAIL rstmid_latency got %0d want 18", e); end
    model(2, 1'b1);
    grab(0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mexp[r][c]) begin
          errors++;
          $display("FAIL rstmid P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mexp[r][c]);
        end
      end
    settle();
  endtask

  task automatic test_back_to_back();
    int e;
    clear_mats();
    for (int d = 0; d < 2; d++) begin ma[d][d] = 256; mp0[d][d] = 256; mq[d][d] = 1; end
    pack_inputs();
    do_load();
    launch(0, 60, e);
    model(2, 1'b1);
    start = 1'b1;
    tick();
    vectors++;
    if (busy_s !== 1'b0) begin errors++; $display("FAIL b2b_ignored_in_done got %b want 0", busy_s); end
    tick();
    start = 1'b0;
    vectors++;
    if (busy_s !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", busy_s); end
    e = 1;
    while (done_s == 1'b0 && e < 60) begin tick(); e++; end
    vectors++;
    if (e !== 18) begin errors++; $display("FAIL b2b_latency got %0d want 18", e); end
    // Second prediction starts from the first result, not from P0.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) mp0[r][c] = mexp[r][c];
    model(2, 1'b1);
    grab(0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (gp[r][c] !== mexp[r][c]) begin
          errors++;
          $display("FAIL b2b P[%0d][%0d] got %0d want %0d", r, c, gp[r][c], mexp[r][c]);
        end
      end
    settle();
  endtask

  task automatic test_random_nos3();
    int e;
    int ra, rp, rq;
    for (int it = 0; it < 8; it++) begin
      ra = (it < 5) ? 400 : 32767;
      rp = (it < 5) ? 2000 : 32767;
      rq = (it < 5) ? 100 : 32767;
      clear_mats();
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          ma[r][c] = rnd(ra); mp0[r][c] = rnd(rp); mq[r][c] = rnd(rq);
        end
      pack_inputs();
      do_load();
      launch(2, 200, e);
      vectors++;
      if (e !== 58) begin errors++; $display("FAIL rand_latency it %0d got %0d want 58", it, e); end
      model(3, 1'b1);
      grab(2);
      vectors++;
      if (ovf_3 !== movf) begin errors++; $display("FAIL rand_ovf it %0d got %b want %b", it, ovf_3, movf); end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          vectors++;
          if (gp[r][c] !== mexp[r][c]) begin
            errors++;
            $display("FAIL rand it %0d P[%0d][%0d] got %0d want %0d", it, r, c, gp[r][c], mexp[r][c]);
          end
        end
      settle();
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_shear();
    test_saturate();
    test_symmetrize();
    test_clk_en();
    test_reset_mid();
    test_back_to_back();
    test_random_nos3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
